// File: rtl/scb_pkg.sv
// Shared types and defaults for the in-order issue hazard scoreboard.
package scb_pkg;

  typedef enum logic [1:0] {
    SCB_RUN,
    SCB_DRAIN,
    SCB_HALTED
  } scbState_t;

  localparam int CNT_W_DEF  = 2;
  localparam int INFL_W_DEF = 3;

  // Largest value a saturating counter of the given width can hold.
  function automatic int satMax(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode / writeback / execute-squash bundle seen by the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_SIZE = 5
);
  logic                issueValidD;
  logic [REG_SIZE-1:0] rs1D;
  logic [REG_SIZE-1:0] rs2D;
  logic                useRs1D;
  logic                useRs2D;
  logic                regWriteD;
  logic [REG_SIZE-1:0] rdD;
  logic                finishD;
  logic                retireW;
  logic                regWriteW;
  logic [REG_SIZE-1:0] rdW;
  logic                squashE;
  logic                regWriteSqE;
  logic [REG_SIZE-1:0] rdSqE;
  logic                stallD;
  logic                halted;
  logic                scbErr;

  modport master (
    output issueValidD, rs1D, rs2D, useRs1D, useRs2D, regWriteD, rdD, finishD,
    output retireW, regWriteW, rdW, squashE, regWriteSqE, rdSqE,
    input  stallD, halted, scbErr
  );

  modport slave (
    input  issueValidD, rs1D, rs2D, useRs1D, useRs2D, regWriteD, rdD, finishD,
    input  retireW, regWriteW, rdW, squashE, regWriteSqE, rdSqE,
    output stallD, halted, scbErr
  );
endinterface

// File: rtl/scb_counter.sv
// Saturating up/down counter with one increment and two decrement strobes;
// underflow clamps to zero and isZero reflects the value after this edge.
module scb_counter
  import scb_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec0,
  input  logic         dec1,
  output logic [W-1:0] count,
  output logic         underflow,
  output logic         isZero
);

  logic        [W-1:0] r_count;
  logic        [W-1:0] w_next;
  logic signed [W+1:0] w_sum;

  // Two spare bits let the net change go negative or past max before clamping.
  always_comb begin
    w_sum     = $signed({2'b00, r_count})
              + $signed({{(W+1){1'b0}}, inc})
              - $signed({{(W+1){1'b0}}, dec0})
              - $signed({{(W+1){1'b0}}, dec1});
    underflow = 1'b0;
    w_next    = r_count;
    if (w_sum < 0) begin
      underflow = 1'b1;
      w_next    = '0;
    end else if (w_sum > $signed((W+2)'(satMax(W)))) begin
      w_next    = '1;
    end else begin
      w_next    = w_sum[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign count  = r_count;
  assign isZero = (w_next == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: RAW stalls, in-flight tracking and finish drain.
// Define SCB_BYPASS_EN to let a same-cycle writeback clear a single pending source.
module hazard_scoreboard
  import scb_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int REG_SIZE  = 5,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int INFL_W    = INFL_W_DEF
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);

  scbState_t r_state;
  scbState_t w_nextState;
  logic      r_scbErr;

  logic [REG_COUNT-1:0][CNT_W-1:0] w_pend;
  logic [REG_COUNT-1:0]            w_pendZero;
  logic [REG_COUNT-1:0]            w_pendUnder;

  logic [INFL_W-1:0] w_infl;
  logic              w_inflZero;
  logic              w_inflUnder;

  logic w_issue;
  logic w_stall;
  logic w_byp1;
  logic w_byp2;
  logic w_rs1Haz;
  logic w_rs2Haz;
  logic w_wawFull;
  logic w_inflFull;

  // x0 is hard-wired: never pending, never in error.
  assign w_pend[0]      = '0;
  assign w_pendZero[0]  = 1'b1;
  assign w_pendUnder[0] = 1'b0;

  genvar g;
  generate
    for (g = 1; g < REG_COUNT; g++) begin : gPend
      scb_counter #(
        .W(CNT_W)
      ) uCnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (w_issue & bus.regWriteD & (bus.rdD == REG_SIZE'(g))),
        .dec0      (bus.retireW & bus.regWriteW & (bus.rdW == REG_SIZE'(g))),
        .dec1      (bus.squashE & bus.regWriteSqE & (bus.rdSqE == REG_SIZE'(g))),
        .count     (w_pend[g]),
        .underflow (w_pendUnder[g]),
        .isZero    (w_pendZero[g])
      );
    end
  endgenerate

  scb_counter #(
    .W(INFL_W)
  ) uInfl (
    .clk       (clk),
    .reset     (reset),
    .inc       (w_issue),
    .dec0      (bus.retireW),
    .dec1      (bus.squashE),
    .count     (w_infl),
    .underflow (w_inflUnder),
    .isZero    (w_inflZero)
  );

`ifdef SCB_BYPASS_EN
  // The regfile writes on negedge, so a single outstanding write retiring now is already readable.
  assign w_byp1 = (w_pend[bus.rs1D] == CNT_W'(1)) & bus.retireW & bus.regWriteW
                & (bus.rdW == bus.rs1D);
  assign w_byp2 = (w_pend[bus.rs2D] == CNT_W'(1)) & bus.retireW & bus.regWriteW
                & (bus.rdW == bus.rs2D);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_comb begin
    w_rs1Haz   = bus.useRs1D & (bus.rs1D != '0) & (w_pend[bus.rs1D] != '0) & ~w_byp1;
    w_rs2Haz   = bus.useRs2D & (bus.rs2D != '0) & (w_pend[bus.rs2D] != '0) & ~w_byp2;
    w_wawFull  = bus.regWriteD & (bus.rdD != '0) & (w_pend[bus.rdD] == '1);
    w_inflFull = (w_infl == '1);
    w_stall    = (r_state != SCB_RUN)
               | (bus.issueValidD & (w_rs1Haz | w_rs2Haz | w_wawFull | w_inflFull));
  end

  assign w_issue = bus.issueValidD & ~w_stall;

  // Drain completes on the edge whose updates leave nothing in flight and nothing pending.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      SCB_RUN: begin
        if (w_issue & bus.finishD) begin
          w_nextState = SCB_DRAIN;
        end
      end
      SCB_DRAIN: begin
        if (w_inflZero & (&w_pendZero)) begin
          w_nextState = SCB_HALTED;
        end
      end
      SCB_HALTED: begin
        w_nextState = SCB_HALTED;
      end
      default: begin
        w_nextState = SCB_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= SCB_RUN;
      r_scbErr <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_scbErr <= r_scbErr | w_inflUnder | (|w_pendUnder);
    end
  end

  assign bus.stallD = w_stall;
  assign bus.halted = (r_state == SCB_HALTED);
  assign bus.scbErr = r_scbErr;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- In-order issue scoreboard between decode and execute.
- Tracks outstanding register writes per architectural register and stalls decode on RAW hazards against in-flight producers.
- Sequences program finish: on a finish instruction it blocks further issue, drains the pipeline, then raises halted.
- Writeback retire strobes and execute-stage squashes release entries.

Parameters:
- REG_COUNT, 32, number of architectural registers; x0 is never tracked.
- REG_SIZE, 5, register index width.
- CNT_W, 2, per-register pending-write counter width; saturates at 2^CNT_W-1.
- INFL_W, 3, in-flight instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- issueValidD  in  1  decode holds a valid instruction.
- rs1D, rs2D  in  REG_SIZE  source indices.
- useRs1D, useRs2D  in  1  instruction reads rs1 / rs2.
- regWriteD  in  1  instruction writes rdD.
- rdD  in  REG_SIZE  destination index.
- finishD  in  1  instruction is SYSTEM/finish.
- retireW  in  1  an instruction leaves writeback this cycle.
- regWriteW  in  1  the retiring instruction writes rdW.
- rdW  in  REG_SIZE  retiring destination.
- squashE  in  1  instruction in execute is killed this cycle.
- regWriteSqE  in  1  the killed instruction had regWrite set.
- rdSqE  in  REG_SIZE  destination of the killed instruction.
- stallD  out  1  hold fetch/decode; nothing issues this cycle.
- halted  out  1  finish drained; sticky until reset.
- scbErr  out  1  sticky protocol error.

Behaviour:
- Reset: all pending counters 0, in-flight counter 0, state RUN, stallD 0, halted 0, scbErr 0.
- issue = issueValidD & ~stallD.
- stallD is combinational and equals 1 when any of the following holds:
  - state != RUN;
  - issueValidD & useRs1D & rs1D != 0 & pend[rs1D] != 0;
  - the same condition for rs2;
  - issueValidD & regWriteD & rdD != 0 & pend[rdD] == max;
  - issueValidD & inflight == max.
- Counters, updated on the rising edge:
  - pend[rdD] += 1 on issue & regWriteD & rdD != 0.
  - pend[rdW] -= 1 on retireW & regWriteW & rdW != 0.
  - pend[rdSqE] -= 1 on squashE & regWriteSqE & rdSqE != 0.
  - Simultaneous inc/dec on the same register nets out.
  - Two decrements on the same register subtract 2.
- In-flight counter:
  - +1 per issue.
  - -1 per retireW.
  - -1 per squashE.
  - Net of all three applied in one cycle.
- Error handling: a decrement below 0 on any counter clamps to 0 and sets scbErr, which is sticky.
- Latency: stall release is visible the cycle after the retire edge; zero-cycle RAW release only via the optional feature.
- FSM:
  - RUN -> DRAIN on issue & finishD. The finish instruction itself counts as in flight.
  - DRAIN: stallD = 1. DRAIN -> HALTED when inflight == 0 and all pend == 0, evaluated after the current edge's updates.
  - A squash of the finish instruction while in DRAIN (squashE with inflight reaching 0 before retire) still completes to HALTED. Squash semantics are owned by execute.
  - HALTED: stallD = 1, halted = 1, terminal until reset.
- Reset asserted mid-operation clears all state immediately, asynchronously.

Optional Feature:
- Macro: SCB_BYPASS_EN.
- Defined: a source hazard is suppressed when pend[rs] == 1 & retireW & regWriteW & rdW == rs. The regfile writes on negedge, so decode reads the fresh value in the same cycle.
- Undefined: no suppression; the instruction stalls one extra cycle.

Decomposition:
- Package scb_pkg: state enum {SCB_RUN, SCB_DRAIN, SCB_HALTED}, CNT_W/INFL_W defaults, saturation-max constants.
- Sub-module scb_counter: one saturating up/down counter with inc, dec0, dec1 inputs, plus underflow and isZero outputs. Instantiated via generate for indices 1..REG_COUNT-1.

Test Plan:
- Reset release, issue x5 write, next cycle read x5 -> stallD = 1; retireW with rdW = 5 -> stallD = 0 the cycle after (with SCB_BYPASS_EN: stallD = 0 in the retire cycle).
- Read x0 with regWriteD to x0 pending -> stallD never 1; pend for x0 never changes.
- Issue 3 writes to x7 (CNT_W = 2) -> fourth write to x7 stalls; one retire -> it issues.
- Issue to x9 and retire x9 in the same cycle with pend[9] = 1 -> pend[9] stays 1; squash of x9 -> 0.
- Retire x4 with pend[4] = 0 -> scbErr = 1, held through later traffic until reset = 0.
- finishD issued with 2 in flight -> stallD = 1 immediately; after 3 retires halted = 1; further issueValidD stays stalled; async reset -> RUN, halted = 0.
